// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encoding, FSM state type and the conditional two's-complement helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Widest value the helper handles; covers a 2*WIDTH product up to WIDTH=64.
    localparam int unsigned MAXW = 128;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Two's-complement negate when neg is set; with neg = sign bit this is |v|.
    function automatic logic [MAXW-1:0] abs_val(input logic [MAXW-1:0] v, input logic neg);
        return neg ? (~v + MAXW'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bundle; master is the pipeline side.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, flush,
        input  stall, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, flush,
        output stall, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step
// over a 2*WIDTH accumulator.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mag,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               qbit
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, mag};
        acc_next = {sum, acc[WIDTH-1:1]};
        qbit     = 1'b0;
        if (div) begin
            // rem_sh < 2*mag, so diff[WIDTH] is exactly the borrow.
            qbit     = ~diff[WIDTH];
            acc_next = {(qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller writing HI/LO; one step per cycle.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once the multiplier bits run out.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state, state_next;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_step, acc_adv, acc_fin, prod;
    logic [WIDTH-1:0]   mag, hi_r, lo_r, fix_hi, fix_lo, mag_a, mag_b;
    logic               is_div, neg_prod, neg_rem, dz, dz_flag, qbit;
    logic               start_ok, op_signed, a_neg, b_neg, b_zero, last, early;

    assign start_ok  = bus.start && !bus.flush && (state != BUSY);
    assign op_signed = !bus.op[0];
    assign a_neg     = op_signed && bus.operand_a[WIDTH-1];
    assign b_neg     = op_signed && bus.operand_b[WIDTH-1];
    assign mag_a     = WIDTH'(abs_val(MAXW'(bus.operand_a), a_neg));
    assign mag_b     = WIDTH'(abs_val(MAXW'(bus.operand_b), b_neg));
    assign b_zero    = bus.op[1] && (bus.operand_b == '0);

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .div     (is_div),
        .acc     (acc),
        .mag     (mag),
        .acc_next(acc_step),
        .qbit    (qbit)
    );

    // Divide leaves bit 0 clear for the quotient bit; multiply reports qbit=0.
    assign acc_adv = {acc_step[2*WIDTH-1:1], acc_step[0] | qbit};

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0]    remain;
    logic [WIDTH-1:0] mask;

    always_comb begin
        remain  = CW'(WIDTH - 1) - count;
        mask    = (WIDTH'(1) << remain) - WIDTH'(1);
        early   = !is_div && ((acc_adv[WIDTH-1:0] & mask) == '0);
        acc_fin = is_div ? acc_adv : (acc_adv >> remain);
    end
`else
    assign early   = 1'b0;
    assign acc_fin = acc_adv;
`endif

    assign last = (count == CW'(WIDTH - 1)) || early;

    always_comb begin
        prod   = (2*WIDTH)'(abs_val(MAXW'(acc_fin), neg_prod));
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            fix_lo = WIDTH'(abs_val(MAXW'(acc_fin[WIDTH-1:0]), neg_prod));
            fix_hi = WIDTH'(abs_val(MAXW'(acc_fin[2*WIDTH-1:WIDTH]), neg_rem));
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start_ok) state_next = BUSY;
            BUSY: begin
                if (bus.flush) begin
                    state_next = IDLE;
                end else if (dz || last) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = start_ok ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            mag      <= '0;
            is_div   <= 1'b0;
            neg_prod <= 1'b0;
            neg_rem  <= 1'b0;
            dz       <= 1'b0;
            dz_flag  <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
        end else begin
            state   <= state_next;
            dz_flag <= 1'b0;
            if (start_ok) begin
                count    <= '0;
                is_div   <= bus.op[1];
                neg_prod <= a_neg ^ b_neg;
                neg_rem  <= a_neg && bus.op[1];
                dz       <= b_zero;
                if (b_zero) begin
                    // Result is fixed up front: HI = raw dividend, LO = all ones.
                    acc <= {bus.operand_a, {WIDTH{1'b1}}};
                    mag <= '0;
                end else if (bus.op[1]) begin
                    acc <= {{WIDTH{1'b0}}, mag_a};
                    mag <= mag_b;
                end else begin
                    acc <= {{WIDTH{1'b0}}, mag_b};
                    mag <= mag_a;
                end
            end else if (state == BUSY && !bus.flush) begin
                if (dz) begin
                    hi_r    <= acc[2*WIDTH-1:WIDTH];
                    lo_r    <= acc[WIDTH-1:0];
                    dz_flag <= 1'b1;
                end else if (last) begin
                    hi_r <= fix_hi;
                    lo_r <= fix_lo;
                end else begin
                    acc   <= acc_adv;
                    count <= count + CW'(1);
                end
            end
        end
    end

    assign bus.busy        = (state == BUSY);
    assign bus.done        = (state == DONE);
    assign bus.stall       = bus.start | (state == BUSY);
    assign bus.div_by_zero = dz_flag;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide controller beside the execute-stage ALU; runs MIPS MULT, MULTU, DIV and DIVU over WIDTH cycles and writes the HI/LO register pair.
- Stalls the pipeline while busy, is aborted by flush, and exposes HI/LO to the execute-stage forwarding muxes for MFHI/MFLO.
- One shift-add or restore-subtract step per cycle; no combinational multiplier.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count; must be even and >= 4.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  execute-stage request, one-cycle qualified
- op  in  2  operation code (muldiv_pkg encoding)
- operand_a  in  WIDTH  Rs value after forwarding (multiplicand/dividend)
- operand_b  in  WIDTH  Rt value after forwarding (multiplier/divisor)
- flush  in  1  abort in-flight operation (branch/exception)
- stall  out  1  hold IF/ID/EX pipeline registers
- busy  out  1  registered; high while iterating
- done  out  1  one-cycle pulse; HI/LO just updated
- div_by_zero  out  1  registered flag with done for DIV/DIVU, divisor 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset values: state IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, counter=0; reset overrides all other inputs, including mid-operation.
- States:
  - IDLE, BUSY, DONE.
  - IDLE/DONE, start=1, flush=0:
    - Latch magnitudes of operands. Signed ops take the two's-complement absolute value; unsigned ops pass through.
    - Latch result-sign flags:
      - product/quotient sign = a[MSB]^b[MSB] for signed ops
      - remainder sign = a[MSB]
    - Counter=0, go to BUSY.
  - DONE with no start: go to IDLE; done returns to 0.
  - BUSY, one step per cycle; after the step with counter=WIDTH-1, go to DONE and register final hi/lo.
    - Multiply: shift-add over a 2*WIDTH accumulator.
    - Divide: restoring, one quotient bit per step.
- Latency: start in cycle N, BUSY in cycles N+1..N+WIDTH, done=1 in cycle N+WIDTH+1. For WIDTH=32, done is 33 cycles after start.
- stall = start | busy, combinational from start. It is high in cycles N..N+WIDTH and low in the done cycle, so a following MFHI/MFLO reads the new values.
- Result mapping:
  - Multiply: hi:lo = 2*WIDTH product. For signed ops the magnitude product is negated if the sign flag is set.
  - Divide: lo = quotient, hi = remainder, each negated per its sign flag.
  - -2^(WIDTH-1) / -1 yields lo=0x80000000, hi=0 (natural truncation, no trap).
- Divide by zero:
  - Detected at start; no iteration. BUSY lasts 1 cycle, done at N+2.
  - hi = operand_a unchanged, lo = all ones, div_by_zero=1 for the done cycle.
- flush:
  - In BUSY: next state IDLE, busy=0; hi/lo keep their pre-start values; no done.
  - Flush with start in the same cycle: start ignored.
- start while BUSY is ignored; the pipeline is stalled, so this is an upstream error, and no assertion is required.
- hi/lo change only on the done transition or on reset.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined, multiply only: if the remaining multiplier shift register is zero after any step, jump to DONE next cycle with the correctly shifted accumulator. MULT 5*3 then completes with done at cycle N+3.
- Divide timing is unchanged.
- Undefined: all non-zero-divisor ops take exactly WIDTH BUSY cycles.

Decomposition:
- muldiv_pkg holds:
  - op encoding: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11
  - state enum: IDLE, BUSY, DONE
  - helper function for two's-complement absolute value
- One sub-module, muldiv_step: combinational single iteration. Inputs are mode, accumulator, and operand magnitude; outputs are the next accumulator and the next quotient bit.
- The FSM, counter and sign fix-up stay in muldiv_sequencer.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 cycles after start, stall high 33 cycles.
- MULT a=0xFFFFFFFD(-3) b=7: hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=0xFFFFFFF9(-7) b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=10 b=0: done at N+2, div_by_zero=1, hi=0x0000000A, lo=0xFFFFFFFF.
- DIV a=0x80000000 b=0xFFFFFFFF: lo=0x80000000, hi=0; separately DIVU 100/7: lo=14, hi=2.
- Preload hi=0x1234, lo=0x5678; start MULTU 6*7, flush at cycle N+10: no done, busy=0 at N+11, hi/lo unchanged; the next start succeeds with lo=42.
- reset at cycle N+5 of an op: cycle after reset shows busy=0, stall=0, hi=lo=0; start asserted while BUSY changes no result.
